// File: rtl/session_timer_ctrl_if.sv
// ============================================================================
// Module : session_timer_ctrl_if
// Brief  : Coin/mode/pause/cancel inputs and BCD display outputs of the
//          session timer controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface session_timer_ctrl_if;
  logic       Coin;
  logic [3:0] Mode;
  logic       Pause;
  logic       Cancel;
  logic [3:0] S_Min;
  logic [3:0] S_Ten;
  logic [3:0] S_One;
  logic       Active;
  logic       Done;
  logic       Reject;

  modport master (
    output Coin, Mode, Pause, Cancel,
    input  S_Min, S_Ten, S_One, Active, Done, Reject
  );

  modport slave (
    input  Coin, Mode, Pause, Cancel,
    output S_Min, S_Ten, S_One, Active, Done, Reject
  );
endinterface

`default_nettype wire

// File: rtl/session_timer_ctrl.sv
// ============================================================================
// Module : session_timer_ctrl
// Brief  : Session FSM, one-second prescaler and BCD M:SS countdown.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module session_timer_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic                 Clk,
  input  logic                 nReset,
  session_timer_ctrl_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] c_tickMax = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] c_prescOne = PW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } stateT;

  stateT         r_state, w_nxtState;
  logic [3:0]    r_min, r_ten, r_one;
  logic [3:0]    w_nxtMin, w_nxtTen, w_nxtOne;
  logic [3:0]    w_decMin, w_decTen, w_decOne;
  logic [PW-1:0] r_presc, w_nxtPresc;
  logic          r_coinD, r_done, r_reject;
  logic          w_nxtDone, w_nxtReject, w_tick, w_coinEv;

  assign w_coinEv = bus.Coin & ~r_coinD;

  // Coin edge register resets high so a coin held through reset is not an edge.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state  <= IDLE;
      r_min    <= 4'd0;
      r_ten    <= 4'd0;
      r_one    <= 4'd0;
      r_presc  <= '0;
      r_coinD  <= 1'b1;
      r_done   <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_nxtState;
      r_min    <= w_nxtMin;
      r_ten    <= w_nxtTen;
      r_one    <= w_nxtOne;
      r_presc  <= w_nxtPresc;
      r_coinD  <= bus.Coin;
      r_done   <= w_nxtDone;
      r_reject <= w_nxtReject;
    end
  end

  always_comb begin
    w_nxtState  = r_state;
    w_nxtMin    = r_min;
    w_nxtTen    = r_ten;
    w_nxtOne    = r_one;
    w_nxtPresc  = r_presc;
    w_nxtDone   = 1'b0;
    w_nxtReject = 1'b0;
    w_tick      = 1'b0;
    w_decMin    = r_min;
    w_decTen    = r_ten;
    w_decOne    = r_one;

    case (r_state)
      IDLE: begin
        if (w_coinEv) begin
          w_nxtPresc = '0;
          case (bus.Mode)
            4'd1: begin w_nxtMin = 4'd1; w_nxtTen = 4'd5; w_nxtOne = 4'd9; w_nxtState = RUNNING; end
            4'd2: begin w_nxtMin = 4'd4; w_nxtTen = 4'd5; w_nxtOne = 4'd9; w_nxtState = RUNNING; end
            4'd3: begin w_nxtMin = 4'd9; w_nxtTen = 4'd5; w_nxtOne = 4'd9; w_nxtState = RUNNING; end
            default: w_nxtReject = 1'b1;
          endcase
        end
      end

      RUNNING, PAUSED: begin
        if (bus.Cancel) begin
          w_nxtState = IDLE;
          w_nxtMin   = 4'd0;
          w_nxtTen   = 4'd0;
          w_nxtOne   = 4'd0;
          w_nxtPresc = '0;
        end else begin
          // The prescaler only advances while running and not being paused.
          if (r_state == RUNNING && !bus.Pause) begin
            if (r_presc == c_tickMax) begin
              w_nxtPresc = '0;
              w_tick     = 1'b1;
            end else begin
              w_nxtPresc = r_presc + c_prescOne;
            end
          end

          if (w_tick) begin
            if (r_one == 4'd0) begin
              w_decOne = 4'd9;
              if (r_ten == 4'd0) begin
                w_decTen = 4'd5;
                w_decMin = r_min - 4'd1;
              end else begin
                w_decTen = r_ten - 4'd1;
              end
            end else begin
              w_decOne = r_one - 4'd1;
            end
          end

          w_nxtMin = w_decMin;
          w_nxtTen = w_decTen;
          w_nxtOne = w_decOne;

          // Extra minute is applied after the decrement of the same cycle.
          if (w_coinEv) begin
            if (w_decMin < 4'd9) begin
              w_nxtMin = w_decMin + 4'd1;
            end else begin
              w_nxtMin = 4'd9;
              w_nxtTen = 4'd5;
              w_nxtOne = 4'd9;
            end
          end

          if (w_tick && !w_coinEv && w_decMin == 4'd0 && w_decTen == 4'd0 && w_decOne == 4'd0) begin
            w_nxtState = IDLE;
            w_nxtDone  = 1'b1;
          end else begin
            w_nxtState = bus.Pause ? PAUSED : RUNNING;
          end
        end
      end

      default: begin
        w_nxtState = IDLE;
        w_nxtMin   = 4'd0;
        w_nxtTen   = 4'd0;
        w_nxtOne   = 4'd0;
        w_nxtPresc = '0;
      end
    endcase
  end

  assign bus.S_Min  = r_min;
  assign bus.S_Ten  = r_ten;
  assign bus.S_One  = r_one;
  assign bus.Active = (r_state == RUNNING) || (r_state == PAUSED);
  assign bus.Done   = r_done;
  assign bus.Reject = r_reject;

endmodule

`default_nettype wire

// File: tb/tb_session_timer_ctrl.sv
// ============================================================================
// Module : tb_session_timer_ctrl
// Brief  : Scoreboard bench for session_timer_ctrl against a seconds-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_session_timer_ctrl;
  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  session_timer_ctrl_if bus();

  session_timer_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .Clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       a;
    logic       d;
    logic       r;
  } obsT;

  obsT expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // Model state: remaining time held as plain seconds.
  int secs, presc;
  bit active, paused, coinPrev, mDone, mRej;

  function automatic obsT modelObs();
    obsT x;
    x.m = 4'(secs / 60);
    x.t = 4'((secs % 60) / 10);
    x.o = 4'(secs % 10);
    x.a = active;
    x.d = mDone;
    x.r = mRej;
    return x;
  endfunction

  function automatic int presetSecs(input logic [3:0] md);
    case (md)
      4'd1: return 119;
      4'd2: return 299;
      4'd3: return 599;
      default: return -1;
    endcase
  endfunction

  task automatic modelReset();
    secs = 0; presc = 0; active = 0; paused = 0;
    coinPrev = 1; mDone = 0; mRej = 0;
  endtask

  task automatic modelStep(input bit coin, input logic [3:0] md, input bit pause, input bit cancel);
    bit ev, ticked;
    ev = coin && !coinPrev;
    coinPrev = coin;
    mDone = 0;
    mRej = 0;
    ticked = 0;
    if (!active) begin
      if (ev) begin
        if (presetSecs(md) > 0) begin
          secs = presetSecs(md); active = 1; paused = 0; presc = 0;
        end else begin
          mRej = 1;
        end
      end
    end else if (cancel) begin
      active = 0; paused = 0; secs = 0; presc = 0;
    end else begin
      if (!paused && !pause) begin
        if (presc == TICK_DIV - 1) begin presc = 0; ticked = 1; end
        else presc++;
      end
      if (ticked) secs--;
      if (ev) secs = (secs / 60 < 9) ? secs + 60 : 599;
      if (secs == 0) begin
        active = 0; paused = 0; mDone = 1;
      end else begin
        paused = pause;
      end
    end
  endtask

  function automatic obsT actual();
    obsT x;
    x = {bus.S_Min, bus.S_Ten, bus.S_One, bus.Active, bus.Done, bus.Reject};
    return x;
  endfunction

  task automatic compare(input string name, input obsT a, input obsT e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0d:%0d%0d act=%0b done=%0b rej=%0b, expected %0d:%0d%0d act=%0b done=%0b rej=%0b",
               name, cyc, a.m, a.t, a.o, a.a, a.d, a.r, e.m, e.t, e.o, e.a, e.d, e.r);
    end
  endtask

  task automatic step(input bit coin, input logic [3:0] md, input bit pause, input bit cancel);
    @(negedge clk);
    bus.Coin = coin; bus.Mode = md; bus.Pause = pause; bus.Cancel = cancel;
    modelStep(coin, md, pause, cancel);
    expQ.push_back(modelObs());
  endtask

  task automatic applyReset(input bit coinLevel, input int cycles);
    @(negedge clk);
    bus.Coin = coinLevel; bus.Mode = 4'd0; bus.Pause = 1'b0; bus.Cancel = 1'b0;
    nReset = 1'b0;
    modelReset();
    #1 compare("async_reset", actual(), modelObs());
    repeat (cycles) begin
      @(negedge clk);
      expQ.push_back(modelObs());
    end
    @(negedge clk);
    nReset = 1'b1;
    modelStep(coinLevel, 4'd0, 1'b0, 1'b0);
    expQ.push_back(modelObs());
  endtask

  // Idle-input steps until the model's next cycle ticks with `target` seconds showing.
  task automatic runUntil(input int target);
    int n = 0;
    while (!(active && secs == target && presc == TICK_DIV - 1) && n < 5000) begin
      step(0, 4'd0, 0, 0);
      n++;
    end
    if (n >= 5000) begin
      errors++;
      $display("FAIL runUntil: target %0d s not reached, model at %0d s", target, secs);
    end
  endtask

  task automatic runToExpiry();
    int n = 0;
    while (active && n < 5000) begin
      step(0, 4'd0, 0, 0);
      n++;
    end
    if (n >= 5000) begin
      errors++;
      $display("FAIL runToExpiry: session still active, model at %0d s", secs);
    end
  endtask

  // Monitor: one expected observation per stimulus cycle.
  initial begin : monitor
    obsT e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        compare("cycle", actual(), e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    bit pz;
    bus.Coin = 1'b0; bus.Mode = 4'd0; bus.Pause = 1'b0; bus.Cancel = 1'b0;
    modelReset();
    applyReset(0, 3);

    // Full Mode 1 session down to natural expiry.
    step(1, 4'd1, 0, 0);
    runToExpiry();
    step(0, 4'd0, 0, 0);

    // Invalid mode in IDLE, Pause ignored in IDLE.
    step(1, 4'd7, 0, 0);
    step(0, 4'd7, 1, 0);
    step(1, 4'd0, 1, 0);
    step(0, 4'd0, 0, 0);

    // Mode 3: extra coin at 9:30 saturates.
    step(1, 4'd3, 0, 0);
    step(0, 4'd0, 0, 0);
    runUntil(571);
    step(0, 4'd0, 0, 0);
    step(1, 4'd0, 0, 0);
    step(0, 4'd0, 0, 1);

    // Mode 2: coin at 4:10 -> 5:10, then pause with a coin while paused.
    step(1, 4'd2, 0, 0);
    step(0, 4'd0, 0, 0);
    runUntil(251);
    step(0, 4'd0, 0, 0);
    step(1, 4'd0, 0, 0);
    step(0, 4'd0, 0, 0);
    step(0, 4'd0, 0, 0);
    repeat (10) step(0, 4'd0, 1, 0);
    step(1, 4'd0, 1, 0);
    repeat (9) step(0, 4'd0, 1, 0);
    repeat (6) step(0, 4'd0, 0, 0);

    // Coin coincident with the tick at 0:01 -> 1:00, no Done.
    runUntil(1);
    step(1, 4'd0, 0, 0);
    runToExpiry();
    step(0, 4'd0, 0, 0);

    // Cancel at 3:27 with a coincident coin edge.
    step(1, 4'd2, 0, 0);
    step(0, 4'd0, 0, 0);
    runUntil(208);
    step(0, 4'd0, 0, 0);
    step(1, 4'd0, 0, 1);
    step(0, 4'd0, 0, 0);

    // Reset mid-session with Coin held high across release.
    step(1, 4'd1, 0, 0);
    repeat (10) step(0, 4'd0, 0, 0);
    applyReset(1, 2);
    repeat (3) step(1, 4'd1, 0, 0);
    step(0, 4'd1, 0, 0);
    step(1, 4'd1, 0, 0);
    repeat (5) step(0, 4'd0, 0, 0);

    // Randomized traffic.
    pz = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) pz = !pz;
      step($urandom_range(0, 29) == 0, 4'($urandom_range(0, 5)), pz,
           $urandom_range(0, 399) == 0);
    end
    step(0, 4'd0, 0, 1);

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected observations left, required 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
